// File: rtl/rx_seq_ctrl_if.sv
// rtl/rx_seq_ctrl_if.sv - receiver sequencer control/status bundle
interface rx_seq_ctrl_if #(
   parameter int N_CH  = 3,
   parameter int CNT_W = 8
);
   logic                    PU_RX;
   logic [N_CH-1:0]         CH_EN;
   logic [N_CH*CNT_W-1:0]   CAL_LEN;
   logic [N_CH-1:0]         RDY_CH;
   logic [N_CH-1:0]         PU_CH;
   logic [N_CH-1:0]         CAL_CH;
   logic                    RDY_RX;
   logic                    FAULT;
   logic [N_CH-1:0]         FAULT_CH;
   logic [2:0]              STATE;

   modport master (
      output PU_RX, CH_EN, CAL_LEN, RDY_CH,
      input  PU_CH, CAL_CH, RDY_RX, FAULT, FAULT_CH, STATE
   );

   modport slave (
      input  PU_RX, CH_EN, CAL_LEN, RDY_CH,
      output PU_CH, CAL_CH, RDY_RX, FAULT, FAULT_CH, STATE
   );
endinterface

// File: rtl/rx_seq_ctrl.sv
// rtl/rx_seq_ctrl.sv - receiver power-up / calibration / ready sequencer
module rx_seq_ctrl #(
   parameter int N_CH  = 3,
   parameter int CNT_W = 8,
   parameter int T_PU  = 10,
   parameter int TMO   = 200
) (
   input  logic          CLK,
   input  logic          RST,
   rx_seq_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PWRUP    = 3'd1,
      S_CAL      = 3'd2,
      S_WAIT_RDY = 3'd3,
      S_READY    = 3'd4,
      S_FLT      = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W:0]   ONE_W    = 1;
   localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(T_PU - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
   logic [N_CH-1:0]        en_q, en_d;
   logic [N_CH*CNT_W-1:0]  len_q, len_d;
   logic [N_CH-1:0]        pu_q, pu_d, cal_q, cal_d, fch_q, fch_d;
   logic                   rdy_q, rdy_d, flt_q, flt_d;
   logic [N_CH-1:0]        cal_keep, not_rdy;
   logic                   all_rdy;

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
   assign not_rdy = en_q & ~bus.RDY_CH;
   assign all_rdy = (not_rdy == '0);

   // A zero length behaves like one: cnt+1 is never below 1.
   always_comb begin
      cal_keep = '0;
      for (int i = 0; i < N_CH; i++)
         cal_keep[i] = en_q[i] && (({1'b0, cnt_q} + ONE_W) < {1'b0, len_q[i*CNT_W +: CNT_W]});
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      len_d   = len_q;
      pu_d    = pu_q;
      cal_d   = cal_q;
      fch_d   = fch_q;
      rdy_d   = rdy_q;
      flt_d   = flt_q;
      if (state_q != S_IDLE && !bus.PU_RX) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         pu_d    = '0;
         cal_d   = '0;
         fch_d   = '0;
         rdy_d   = 1'b0;
         flt_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.PU_RX) begin
                  state_d = S_PWRUP;
                  en_d    = bus.CH_EN;
                  len_d   = bus.CAL_LEN;
                  pu_d    = bus.CH_EN;
                  cnt_d   = '0;
               end
            end
            S_PWRUP: begin
               if (cnt_q == PU_LAST) begin
                  state_d = S_CAL;
                  cal_d   = en_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_CAL: begin
               cal_d = cal_keep;
               cnt_d = cnt_inc;
               if (cal_keep == '0) begin
                  state_d = S_WAIT_RDY;
                  cnt_d   = '0;
               end
            end
            S_WAIT_RDY: begin
               if (all_rdy) begin
                  state_d = S_READY;
                  rdy_d   = 1'b1;
               end else if (cnt_q == TMO_LAST) begin
                  state_d = S_FLT;
                  flt_d   = 1'b1;
                  fch_d   = not_rdy;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_READY: begin
               if (!all_rdy) begin
                  state_d = S_FLT;
                  rdy_d   = 1'b0;
                  flt_d   = 1'b1;
                  fch_d   = not_rdy;
               end
            end
            S_FLT: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         en_q    <= '0;
         len_q   <= '0;
         pu_q    <= '0;
         cal_q   <= '0;
         fch_q   <= '0;
         rdy_q   <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         len_q   <= len_d;
         pu_q    <= pu_d;
         cal_q   <= cal_d;
         fch_q   <= fch_d;
         rdy_q   <= rdy_d;
         flt_q   <= flt_d;
      end
   end

   assign bus.PU_CH    = pu_q;
   assign bus.CAL_CH   = cal_q;
   assign bus.RDY_RX   = rdy_q;
   assign bus.FAULT    = flt_q;
   assign bus.FAULT_CH = fch_q;
   assign bus.STATE    = state_q;
endmodule

// File: tb/tb_rx_seq_ctrl.sv
// tb/tb_rx_seq_ctrl.sv - directed self-checking bench for rx_seq_ctrl
module tb_rx_seq_ctrl;
   logic CLK;
   logic RST;
   int   n_chk;
   int   n_err;

   rx_seq_ctrl_if #(.N_CH(3), .CNT_W(8)) bus ();

   rx_seq_ctrl #(.N_CH(3), .CNT_W(8), .T_PU(10), .TMO(200)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int st, input int pu, input int cal,
                          input int rdy, input int flt, input int fch);
      chk({tag, ".state"},    32'(bus.STATE),    st);
      chk({tag, ".pu_ch"},    32'(bus.PU_CH),    pu);
      chk({tag, ".cal_ch"},   32'(bus.CAL_CH),   cal);
      chk({tag, ".rdy_rx"},   32'(bus.RDY_RX),   rdy);
      chk({tag, ".fault"},    32'(bus.FAULT),    flt);
      chk({tag, ".fault_ch"}, 32'(bus.FAULT_CH), fch);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      RST = 1'b1;
      bus.PU_RX   = 1'b0;
      bus.CH_EN   = '0;
      bus.CAL_LEN = '0;
      bus.RDY_CH  = '0;
      tick(2);
      chk_out("reset", 0, 0, 0, 0, 0, 0);
      RST = 1'b0;
      tick(1);
      chk_out("idle", 0, 0, 0, 0, 0, 0);

      // full sequence, lengths 25/30/40
      bus.CH_EN   = 3'b111;
      bus.CAL_LEN = {8'd40, 8'd30, 8'd25};
      bus.PU_RX   = 1'b1;
      tick(1);
      chk_out("pwrup0", 1, 7, 0, 0, 0, 0);
      bus.CH_EN   = 3'b000;
      bus.CAL_LEN = '0;
      tick(9);
      chk_out("pwrup9", 1, 7, 0, 0, 0, 0);
      tick(1);
      chk_out("cal0", 2, 7, 7, 0, 0, 0);
      tick(24);
      chk("cal24", 32'(bus.CAL_CH), 7);
      tick(1);
      chk("cal25", 32'(bus.CAL_CH), 6);
      tick(4);
      chk("cal29", 32'(bus.CAL_CH), 6);
      tick(1);
      chk("cal30", 32'(bus.CAL_CH), 4);
      bus.RDY_CH = 3'b111;
      tick(9);
      chk_out("cal39", 2, 7, 4, 0, 0, 0);
      tick(1);
      chk_out("wait0", 3, 7, 0, 0, 0, 0);
      tick(1);
      chk_out("ready", 4, 7, 0, 1, 0, 0);

      // ready loss on channel 2
      bus.RDY_CH = 3'b011;
      tick(1);
      chk_out("loss", 5, 7, 0, 0, 1, 4);
      bus.RDY_CH = 3'b111;
      tick(1);
      chk_out("loss_hold", 5, 7, 0, 0, 1, 4);
      bus.PU_RX = 1'b0;
      tick(1);
      chk_out("loss_clr", 0, 0, 0, 0, 0, 0);

      // timeout with channel 1 never ready
      bus.CH_EN   = 3'b111;
      bus.CAL_LEN = {8'd1, 8'd1, 8'd1};
      bus.RDY_CH  = 3'b101;
      bus.PU_RX   = 1'b1;
      tick(11);
      chk_out("tmo_cal0", 2, 7, 7, 0, 0, 0);
      tick(1);
      chk_out("tmo_w0", 3, 7, 0, 0, 0, 0);
      tick(199);
      chk_out("tmo_w199", 3, 7, 0, 0, 0, 0);
      tick(1);
      chk_out("tmo_flt", 5, 7, 0, 0, 1, 2);
      bus.PU_RX = 1'b0;
      tick(1);
      chk_out("tmo_clr", 0, 0, 0, 0, 0, 0);

      // ready arriving on the timeout cycle wins
      bus.PU_RX = 1'b1;
      tick(12);
      chk("edge_w0", 32'(bus.STATE), 3);
      tick(199);
      chk("edge_w199", 32'(bus.STATE), 3);
      bus.RDY_CH = 3'b111;
      tick(1);
      chk_out("edge_win", 4, 7, 0, 1, 0, 0);
      bus.PU_RX = 1'b0;
      tick(1);

      // channel 1 disabled, zero length on channel 0
      bus.CH_EN   = 3'b101;
      bus.CAL_LEN = {8'd3, 8'd7, 8'd0};
      bus.RDY_CH  = 3'b101;
      bus.PU_RX   = 1'b1;
      tick(1);
      chk_out("dis_pwrup", 1, 5, 0, 0, 0, 0);
      tick(10);
      chk_out("dis_cal0", 2, 5, 5, 0, 0, 0);
      tick(1);
      chk_out("dis_cal1", 2, 5, 4, 0, 0, 0);
      tick(2);
      chk_out("dis_wait", 3, 5, 0, 0, 0, 0);
      tick(1);
      chk_out("dis_ready", 4, 5, 0, 1, 0, 0);
      bus.PU_RX = 1'b0;
      tick(1);

      // reset in the middle of calibration
      bus.CH_EN   = 3'b111;
      bus.CAL_LEN = {8'd20, 8'd20, 8'd20};
      bus.RDY_CH  = 3'b111;
      bus.PU_RX   = 1'b1;
      tick(14);
      chk_out("rst_midcal", 2, 7, 7, 0, 0, 0);
      RST = 1'b1;
      tick(1);
      chk_out("rst_hit", 0, 0, 0, 0, 0, 0);
      RST = 1'b0;
      bus.CH_EN = 3'b011;
      tick(1);
      chk_out("rst_restart", 1, 3, 0, 0, 0, 0);

      // power-down during PWRUP, restart with fresh enables
      tick(3);
      bus.PU_RX = 1'b0;
      tick(1);
      chk_out("pd_idle", 0, 0, 0, 0, 0, 0);
      bus.CH_EN   = 3'b110;
      bus.CAL_LEN = {8'd4, 8'd2, 8'd9};
      bus.RDY_CH  = 3'b110;
      bus.PU_RX   = 1'b1;
      tick(1);
      chk_out("re_pwrup", 1, 6, 0, 0, 0, 0);
      tick(10);
      chk_out("re_cal0", 2, 6, 6, 0, 0, 0);
      tick(2);
      chk("re_cal2", 32'(bus.CAL_CH), 4);
      tick(2);
      chk_out("re_wait", 3, 6, 0, 0, 0, 0);
      tick(1);
      chk_out("re_ready", 4, 6, 0, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
